// File: rtl/cpu2mem_pkg.sv
// Shared types and defaults for the cpu2mem memory port and its arbiters.
package cpu2mem_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  typedef logic [DEF_AW-1:0] addr_t;
  typedef logic [DEF_DW-1:0] data_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select; a lone requester always wins,
// a tie goes to the requester that did not win last time.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       any,
  output logic       win
);

  assign any = |req;
  assign win = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising instruction-fetch and data-load reads
// onto the single cpu2mem port, with response routing and a hung-read timeout.
module mem_port_arbiter
  import cpu2mem_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  output logic [1:0]    gnt_o,
  output logic [1:0]    rvalid_o,
  output logic [DW-1:0] rdata_o,
  output logic          rerr_o,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  input  logic [DW-1:0] mem_data,
  input  logic          mem_valid,
  output logic          dbg_state
);

  localparam int TCW = $clog2(TIMEOUT);

  // Handshakes: req_i[i] is held until gnt_o[i] pulses; mem_read stays high
  // from grant until the edge that samples mem_valid (or the timeout fires);
  // rvalid_o[i] is a one-cycle pulse qualifying rdata_o and rerr_o.

  arb_state_t     state;
  logic           last;
  logic           owner;
  logic [TCW-1:0] tcnt;
  logic           any;
  logic           win;

  rr_pick2 u_pick (
    .req  (req_i),
    .last (last),
    .any  (any),
    .win  (win)
  );

  assign dbg_state = (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      tcnt     <= '0;
      gnt_o    <= '0;
      rvalid_o <= '0;
      rdata_o  <= '0;
      rerr_o   <= 1'b0;
      mem_addr <= '0;
      mem_read <= 1'b0;
    end else begin
      gnt_o    <= '0;
      rvalid_o <= '0;
      rerr_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            gnt_o    <= win ? 2'b10 : 2'b01;
            mem_addr <= win ? addr1_i : addr0_i;
            mem_read <= 1'b1;
            owner    <= win;
            last     <= win;
            tcnt     <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // A response arriving on the expiry cycle is still delivered normally.
          if (mem_valid) begin
            rdata_o  <= mem_data;
            rvalid_o <= owner ? 2'b10 : 2'b01;
            mem_read <= 1'b0;
            state    <= IDLE;
          end else if (tcnt == TCW'(TIMEOUT - 1)) begin
            rdata_o  <= '0;
            rvalid_o <= owner ? 2'b10 : 2'b01;
            rerr_o   <= 1'b1;
            mem_read <= 1'b0;
            state    <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: every cycle's outputs are compared
// against hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_i = '0;
  logic [AW-1:0] addr0_i = '0;
  logic [AW-1:0] addr1_i = '0;
  logic [1:0]    gnt_o;
  logic [1:0]    rvalid_o;
  logic [DW-1:0] rdata_o;
  logic          rerr_o;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic [DW-1:0] mem_data = '0;
  logic          mem_valid = 1'b0;
  logic          dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_rdata = '0;
  logic [AW-1:0] exp_addr = '0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .addr0_i   (addr0_i),
    .addr1_i   (addr1_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .rerr_o    (rerr_o),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bundle order: gnt, rvalid, rerr, rdata, mem_read, mem_addr, state.
  task automatic chk(input string tag, input logic [1:0] gnt, input logic [1:0] rv,
                     input logic err, input logic [DW-1:0] rd, input logic mr,
                     input logic [AW-1:0] ma, input logic st);
    logic [70:0] got;
    logic [70:0] exp;
    got = {gnt_o, rvalid_o, rerr_o, rdata_o, mem_read, mem_addr, dbg_state};
    exp = {gnt, rv, err, rd, mr, ma, st};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got gnt=%b rv=%b err=%b rd=%h mr=%b ma=%h st=%b exp gnt=%b rv=%b err=%b rd=%h mr=%b ma=%h st=%b",
             tag, gnt_o, rvalid_o, rerr_o, rdata_o, mem_read, mem_addr, dbg_state,
             gnt, rv, err, rd, mr, ma, st);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_i = '0;
    mem_valid = 1'b0;
    step();
    step();
    exp_rdata = '0;
    exp_addr  = '0;
    chk("reset", 2'b00, 2'b00, 1'b0, '0, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] w_gnt;
    logic [AW-1:0] w_addr;

    // 1: single fetch, memory answers on the cycle after the grant
    do_reset();
    req_i = 2'b01; addr0_i = 32'h10;
    step();
    exp_addr = 32'h10;
    chk("t1_gnt", 2'b01, 2'b00, 1'b0, exp_rdata, 1'b1, exp_addr, 1'b1);
    req_i = 2'b00; mem_valid = 1'b1; mem_data = 32'hCAFE;
    step();
    exp_rdata = 32'hCAFE;
    chk("t1_rsp", 2'b00, 2'b01, 1'b0, exp_rdata, 1'b0, exp_addr, 1'b0);
    mem_valid = 1'b0;
    step();
    chk("t1_idle", 2'b00, 2'b00, 1'b0, exp_rdata, 1'b0, exp_addr, 1'b0);

    // 2: both requesting continuously from a fresh reset -> 0,1,0,1
    do_reset();
    req_i = 2'b11; addr0_i = 32'h100; addr1_i = 32'h200;
    for (int k = 0; k < 4; k++) begin
      w_gnt  = (k % 2 == 0) ? 2'b01 : 2'b10;
      w_addr = (k % 2 == 0) ? 32'h100 : 32'h200;
      step();
      exp_addr = w_addr;
      chk($sformatf("t2_gnt%0d", k), w_gnt, 2'b00, 1'b0, exp_rdata, 1'b1, exp_addr, 1'b1);
      mem_valid = 1'b1; mem_data = 32'hD000 + k;
      step();
      exp_rdata = 32'hD000 + k;
      chk($sformatf("t2_rsp%0d", k), 2'b00, w_gnt, 1'b0, exp_rdata, 1'b0, exp_addr, 1'b0);
      mem_valid = 1'b0;
    end
    req_i = 2'b00;
    step();
    chk("t2_idle", 2'b00, 2'b00, 1'b0, exp_rdata, 1'b0, exp_addr, 1'b0);

    // 3: memory never answers -> error response 16 cycles after the grant
    req_i = 2'b01; addr0_i = 32'h300;
    step();
    exp_addr = 32'h300;
    chk("t3_gnt", 2'b01, 2'b00, 1'b0, exp_rdata, 1'b1, exp_addr, 1'b1);
    req_i = 2'b00;
    for (int c = 1; c < TIMEOUT; c++) begin
      step();
      chk($sformatf("t3_wait%0d", c), 2'b00, 2'b00, 1'b0, exp_rdata, 1'b1, exp_addr, 1'b1);
    end
    step();
    exp_rdata = '0;
    chk("t3_tmo", 2'b00, 2'b01, 1'b1, exp_rdata, 1'b0, exp_addr, 1'b0);
    step();
    chk("t3_after", 2'b00, 2'b00, 1'b0, exp_rdata, 1'b0, exp_addr, 1'b0);

    // 4: data arrives exactly on the expiry cycle -> normal response
    req_i = 2'b10; addr1_i = 32'h400;
    step();
    exp_addr = 32'h400;
    chk("t4_gnt", 2'b10, 2'b00, 1'b0, exp_rdata, 1'b1, exp_addr, 1'b1);
    req_i = 2'b00;
    for (int c = 1; c < TIMEOUT; c++) begin
      step();
      chk($sformatf("t4_wait%0d", c), 2'b00, 2'b00, 1'b0, exp_rdata, 1'b1, exp_addr, 1'b1);
    end
    mem_valid = 1'b1; mem_data = 32'hBEEF;
    step();
    exp_rdata = 32'hBEEF;
    chk("t4_rsp", 2'b00, 2'b10, 1'b0, exp_rdata, 1'b0, exp_addr, 1'b0);
    mem_valid = 1'b0;

    // 5: reset mid-transaction aborts the read; last returns to 1
    req_i = 2'b01; addr0_i = 32'h500;
    step();
    exp_addr = 32'h500;
    chk("t5_gnt", 2'b01, 2'b00, 1'b0, exp_rdata, 1'b1, exp_addr, 1'b1);
    req_i = 2'b00;
    step();
    step();
    chk("t5_busy", 2'b00, 2'b00, 1'b0, exp_rdata, 1'b1, exp_addr, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    exp_rdata = '0; exp_addr = '0;
    chk("t5_async", 2'b00, 2'b00, 1'b0, '0, 1'b0, '0, 1'b0);
    mem_valid = 1'b1; mem_data = 32'h5555;
    step();
    chk("t5_held", 2'b00, 2'b00, 1'b0, '0, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
    step();
    chk("t5_rel", 2'b00, 2'b00, 1'b0, '0, 1'b0, '0, 1'b0);
    mem_valid = 1'b0;
    req_i = 2'b11; addr0_i = 32'h600; addr1_i = 32'h700;
    step();
    exp_addr = 32'h600;
    chk("t5_regnt", 2'b01, 2'b00, 1'b0, exp_rdata, 1'b1, exp_addr, 1'b1);
    req_i = 2'b00; mem_valid = 1'b1; mem_data = 32'h6666;
    step();
    exp_rdata = 32'h6666;
    chk("t5_rsp", 2'b00, 2'b01, 1'b0, exp_rdata, 1'b0, exp_addr, 1'b0);
    mem_valid = 1'b0;

    // 6: stray mem_valid while idle is ignored
    mem_valid = 1'b1; mem_data = 32'h1234;
    step();
    chk("t6_stray", 2'b00, 2'b00, 1'b0, exp_rdata, 1'b0, exp_addr, 1'b0);
    mem_valid = 1'b0;
    step();
    chk("t6_idle", 2'b00, 2'b00, 1'b0, exp_rdata, 1'b0, exp_addr, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
